// File: rtl/alu8_issue_pkg.sv
// Shared definitions for the ALU issue block: op codes, default depths and
// the packed layouts of the command and response FIFO words.
package alu8_issue_pkg;

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ASL = 4'b1010;

  localparam int DEF_CMD_DEPTH = 4;
  localparam int DEF_RSP_DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] shift;
  } cmd_t;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       err;
  } rsp_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
      OP_SHR, OP_SHL, OP_ASR, OP_ASL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu8_fifo.sv
// Parameterised synchronous FIFO with registered pointers and an occupancy
// count; the head word is presented combinationally on rd_data.
module alu8_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // NOTE: every signal gets a default before the conditional updates, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guards every read,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count_q == (AW+1)'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && count_q == '0));

endmodule

// File: rtl/alu8_issue.sv
// Command queue, credit-gated issue to an external one-cycle ALU, two-stage
// in-flight tracking and an in-order response queue.
module alu8_issue
  import alu8_issue_pkg::*;
#(
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_shift,
  output logic [3:0] alu_op_code,
  output logic [7:0] alu_operand_1,
  output logic [7:0] alu_operand_2,
  output logic [2:0] alu_shift_rotate,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_err
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  cmd_t           cmd_in, cmd_head;
  logic [$bits(cmd_t)-1:0] cmd_rd_data;
  logic [CCW-1:0] cmd_count;
  rsp_t           rsp_in, rsp_head;
  logic [$bits(rsp_t)-1:0] rsp_rd_data;
  logic [RCW-1:0] rsp_count;
  logic [RCW:0]   rsp_used;
  logic           cmd_push, issue, rsp_push, rsp_pop;

  cmd_t alu_q, alu_d;
  logic s1_v_q, s1_v_d, s1_err_q, s1_err_d;
  logic s2_v_q, s2_v_d, s2_err_q, s2_err_d;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, shift: cmd_shift};
  assign cmd_ready = (cmd_count != CCW'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_t'(cmd_rd_data);

  // Credits: buffered responses plus in-flight ops may never exceed the
  // response queue, so a stage-2 push always finds room.
  assign rsp_used = (RCW+1)'(rsp_count) + (RCW+1)'(s1_v_q) + (RCW+1)'(s2_v_q);
  assign issue    = (cmd_count != '0) && (rsp_used < (RCW+1)'(RSP_DEPTH));

  alu8_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (issue),
    .rd_data   (cmd_rd_data),
    .count     (cmd_count)
  );

  always_comb begin
    alu_d    = '0;
    s1_v_d   = issue;
    s1_err_d = issue && !is_legal_op(cmd_head.op);
    s2_v_d   = s1_v_q;
    s2_err_d = s1_err_q;
    if (issue) alu_d = cmd_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_err_q <= 1'b0;
      s2_v_q   <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      alu_q    <= alu_d;
      s1_v_q   <= s1_v_d;
      s1_err_q <= s1_err_d;
      s2_v_q   <= s2_v_d;
      s2_err_q <= s2_err_d;
    end
  end

  assign alu_op_code      = alu_q.op;
  assign alu_operand_1    = alu_q.a;
  assign alu_operand_2    = alu_q.b;
  assign alu_shift_rotate = alu_q.shift;

  // Illegal ops still occupy a slot so ordering holds; the ALU output is dropped.
  always_comb begin
    rsp_in = '{result: alu_result, carry: alu_carry, err: 1'b0};
    if (s2_err_q) rsp_in = '{result: 8'h00, carry: 1'b0, err: 1'b1};
  end

  assign rsp_push = s2_v_q;
  assign rsp_pop  = rsp_valid && rsp_ready;

  alu8_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .rd_data   (rsp_rd_data),
    .count     (rsp_count)
  );

  assign rsp_head   = rsp_t'(rsp_rd_data);
  assign rsp_valid  = (rsp_count != '0);
  assign rsp_result = rsp_valid ? rsp_head.result : 8'h00;
  assign rsp_carry  = rsp_valid && rsp_head.carry;
  assign rsp_err    = rsp_valid && rsp_head.err;

endmodule
